psum_drain: RTL and testbench

Consumer of the systolic array's per-row partial-sum stream. Captures each row's `psum_valid`/data/address beats into small per-row FIFOs, merges them with a round-robin arbiter, and issues single-word writes into the output block RAM over a valid/ready port. It tracks the end of a compute pass (controller `done`) and pulses `drain_done` once every captured psum has been written.

---
 rtl/ctrl_pkg.sv | 17 +
 rtl/psum_fifo.sv | 69 ++++++
 rtl/psum_drain.sv | 172 +++++++++++++++++
 tb/tb_psum_drain.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared controller definitions: drain FSM states and default
// array dimensions used by the compute controller and psum drain.
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_t;

    localparam int DEF_ARRAY_ROWS = 3;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ROW_STRIDE = 3;
    localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/psum_fifo.sv
// Small synchronous FIFO with registered full/empty flags.
// A push while full is taken only when a pop happens in the same cycle.
module psum_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
        full_d  = (cnt_d == (AW+1)'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            if (do_push && !clr) mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/psum_drain.sv
// Drains per-row partial sums into the output RAM through per-row
// FIFOs, a round-robin arbiter and a single registered write port.
module psum_drain
    import ctrl_pkg::*;
#(
    parameter int ARRAY_ROWS = DEF_ARRAY_ROWS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ROW_STRIDE = DEF_ROW_STRIDE,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [0:ARRAY_ROWS-1]              psum_valid,
    input  logic [0:ARRAY_ROWS-1][DATA_W-1:0]  psum_data,
    input  logic [0:ARRAY_ROWS-1][31:0]        psum_addr,
    input  logic                               ctrl_done,
    output logic                               mem_wr_en,
    output logic [31:0]                        mem_wr_addr,
    output logic [DATA_W-1:0]                  mem_wr_data,
    input  logic                               mem_wr_ready,
    output logic                               busy,
    output logic                               drain_done,
    output logic                               overflow,
    output logic [15:0]                        write_count
);

    localparam int FW = 32 + DATA_W;
    localparam int PW = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;

    drain_state_t state_q, state_d;

    logic [FW-1:0]         fifo_dout [ARRAY_ROWS];
    logic [ARRAY_ROWS-1:0] fifo_full, fifo_empty, push, pop;
    logic                  clr, running, found, can_take, do_pop, drop;
    logic [PW-1:0]         ptr_q, ptr_d, grant, cand;

    logic              wr_en_q, wr_en_d;
    logic [31:0]       wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       wcnt_q, wcnt_d;

    function automatic logic [PW-1:0] wrap_row(input int v);
        return (v >= ARRAY_ROWS) ? PW'(v - ARRAY_ROWS) : PW'(v);
    endfunction

    for (genvar r = 0; r < ARRAY_ROWS; r++) begin : g_row
        logic [FW-1:0] din;
        assign din = {32'(r * ROW_STRIDE) + psum_addr[r], psum_data[r]};
        psum_fifo #(
            .WIDTH(FW),
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (clr),
            .push (push[r]),
            .pop  (pop[r]),
            .din  (din),
            .dout (fifo_dout[r]),
            .full (fifo_full[r]),
            .empty(fifo_empty[r])
        );
    end

    always_comb begin
        state_d   = state_q;
        clr       = 1'b0;
        running   = (state_q == RUN) || (state_q == FLUSH);
        found     = 1'b0;
        grant     = '0;
        cand      = '0;
        push      = '0;
        pop       = '0;
        ptr_d     = ptr_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wcnt_d    = wcnt_q;

        for (int r = 0; r < ARRAY_ROWS; r++) push[r] = running && psum_valid[r];

        for (int i = 0; i < ARRAY_ROWS; i++) begin
            cand = wrap_row(int'(ptr_q) + i);
            if (!found && !fifo_empty[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end

        can_take = !wr_en_q || mem_wr_ready;
        do_pop   = found && can_take;

        if (wr_en_q && mem_wr_ready) begin
            wr_en_d = 1'b0;
            wcnt_d  = wcnt_q + 16'd1;
        end
        if (do_pop) begin
            pop[grant] = 1'b1;
            ptr_d      = wrap_row(int'(grant) + 1);
            wr_en_d    = 1'b1;
            wr_addr_d  = fifo_dout[grant][FW-1:DATA_W];
            wr_data_d  = fifo_dout[grant][DATA_W-1:0];
        end

        // a full FIFO still takes the beat when it is being popped
        drop  = |(push & fifo_full & ~pop);
        ovf_d = ovf_q || drop;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    clr     = 1'b1;
                end
            end
            RUN: begin
                if (ctrl_done) state_d = FLUSH;
            end
            FLUSH: begin
                if (&fifo_empty && !wr_en_q && !(|push)) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (clr) begin
            ptr_d  = '0;
            ovf_d  = 1'b0;
            wcnt_d = '0;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign busy        = busy_q;
    assign drain_done  = done_q;
    assign overflow    = ovf_q;
    assign write_count = wcnt_q;

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain with a per-row write scoreboard.
// Expected writes are queued when beats are driven and retired on accept.
module tb_psum_drain;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [0:2]        psum_valid = '0;
    logic [0:2][31:0]  psum_data = '0;
    logic [0:2][31:0]  psum_addr = '0;
    logic              ctrl_done = 1'b0;
    logic              mem_wr_en;
    logic [31:0]       mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic              ready = 1'b1;
    logic              busy, drain_done, overflow;
    logic [15:0]       write_count;

    int tests = 0;
    int fails = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] q2[$];

    psum_drain dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .psum_valid  (psum_valid),
        .psum_data   (psum_data),
        .psum_addr   (psum_addr),
        .ctrl_done   (ctrl_done),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_ready(ready),
        .busy        (busy),
        .drain_done  (drain_done),
        .overflow    (overflow),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int r, input logic [31:0] a,
                            input logic [31:0] d);
        logic [63:0] e;
        e = {32'(r * 3) + a, d};
        case (r)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // drive one beat cycle; rows in keep are expected to reach the RAM
    task automatic beat(input logic [0:2] v, input logic [0:2] keep,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [31:0] d2);
        psum_valid = v;
        psum_addr  = {a0, a1, a2};
        psum_data  = {d0, d1, d2};
        if (v[0] && keep[0]) push_exp(0, a0, d0);
        if (v[1] && keep[1]) push_exp(1, a1, d1);
        if (v[2] && keep[2]) push_exp(2, a2, d2);
        step();
        psum_valid = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_ctrl_done();
        ctrl_done = 1'b1;
        step();
        ctrl_done = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!drain_done && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_drain_done"}, 64'(drain_done), 64'd1);
        step();
        chk({tag, "_done_pulse"}, 64'(drain_done), 64'd0);
        chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
        chk({tag, "_sb_empty"}, 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    endtask

    logic        stall_prev = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        logic [63:0] e;
        int          row;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_en", 64'(mem_wr_en), 64'd1);
                chk("hold_addr", 64'(mem_wr_addr), 64'(prev_addr));
                chk("hold_data", 64'(mem_wr_data), 64'(prev_data));
            end
            if (mem_wr_en && ready) begin
                row = int'(mem_wr_addr / 32'd3);
                e = '1;
                if (row == 0 && q0.size() > 0) e = q0.pop_front();
                else if (row == 1 && q1.size() > 0) e = q1.pop_front();
                else if (row == 2 && q2.size() > 0) e = q2.pop_front();
                chk("write", {mem_wr_addr, mem_wr_data}, e);
            end
            stall_prev = mem_wr_en && !ready;
            prev_addr  = mem_wr_addr;
            prev_data  = mem_wr_data;
        end
    end

    initial begin
        int cnt[3];
        logic [0:2] diag[5];

        // reset state
        step();
        chk("rst_en", 64'(mem_wr_en), 64'd0);
        chk("rst_addr", 64'(mem_wr_addr), 64'd0);
        chk("rst_data", 64'(mem_wr_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(drain_done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_wcnt", 64'(write_count), 64'd0);
        rst_n = 1'b1;
        step();

        // ctrl_done while idle is ignored
        do_ctrl_done();
        chk("idle_ctrl_done", 64'(busy), 64'd0);

        // single row, latency t+2
        ready = 1'b1;
        do_start();
        chk("t1_busy", 64'(busy), 64'd1);
        beat(3'b100, 3'b111, 0, 0, 0, 10, 0, 0);
        chk("t1_lat_en", 64'(mem_wr_en), 64'd0);
        beat(3'b100, 3'b111, 1, 0, 0, 11, 0, 0);
        chk("t1_lat_en2", 64'(mem_wr_en), 64'd1);
        chk("t1_lat_wr", {mem_wr_addr, mem_wr_data}, {32'd0, 32'd10});
        beat(3'b100, 3'b111, 2, 0, 0, 12, 0, 0);
        do_ctrl_done();
        wait_done("t1");
        chk("t1_wcnt", 64'(write_count), 64'd3);

        // diagonal 3x3
        diag = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b001};
        cnt = '{0, 0, 0};
        do_start();
        for (int s = 0; s < 5; s++) begin
            beat(diag[s], 3'b111, cnt[0], cnt[1], cnt[2],
                 100 + cnt[0], 110 + cnt[1], 120 + cnt[2]);
            for (int r = 0; r < 3; r++) if (diag[s][r]) cnt[r]++;
        end
        do_ctrl_done();
        wait_done("t2");
        chk("t2_wcnt", 64'(write_count), 64'd9);
        chk("t2_ovf", 64'(overflow), 64'd0);

        // backpressure mid-stream
        do_start();
        for (int i = 0; i < 3; i++)
            beat(3'b101, 3'b111, i, 0, i, 200 + i, 0, 220 + i);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t3_wcnt_hold", 64'(write_count), 64'd1);
        chk("t3_en", 64'(mem_wr_en), 64'd1);
        chk("t3_wr", {mem_wr_addr, mem_wr_data}, {32'd6, 32'd220});
        ready = 1'b1;
        do_ctrl_done();
        wait_done("t3");
        chk("t3_wcnt", 64'(write_count), 64'd6);

        // overflow: output register occupied, row 1 pushes 5 beats
        do_start();
        ready = 1'b0;
        beat(3'b100, 3'b111, 0, 0, 0, 40, 0, 0);
        beat(3'b010, 3'b111, 0, 0, 0, 0, 50, 0);
        beat(3'b010, 3'b111, 0, 1, 0, 0, 51, 0);
        beat(3'b010, 3'b111, 0, 2, 0, 0, 52, 0);
        beat(3'b010, 3'b111, 0, 0, 0, 0, 53, 0);
        beat(3'b010, 3'b000, 0, 1, 0, 0, 54, 0);
        chk("t4_ovf", 64'(overflow), 64'd1);
        ready = 1'b1;
        do_ctrl_done();
        wait_done("t4");
        chk("t4_wcnt", 64'(write_count), 64'd5);
        chk("t4_ovf_sticky", 64'(overflow), 64'd1);

        // full FIFO popped in the same cycle as a push
        do_start();
        chk("t5_ovf_clr", 64'(overflow), 64'd0);
        ready = 1'b0;
        for (int i = 0; i < 5; i++)
            beat(3'b001, 3'b111, 0, 0, i % 3, 0, 0, 60 + i);
        ready = 1'b1;
        beat(3'b001, 3'b111, 0, 0, 2, 0, 0, 65);
        chk("t5_ovf", 64'(overflow), 64'd0);
        do_ctrl_done();
        wait_done("t5");
        chk("t5_wcnt", 64'(write_count), 64'd6);

        // reset during FLUSH with 2 entries queued
        do_start();
        ready = 1'b0;
        for (int i = 0; i < 3; i++)
            beat(3'b100, 3'b000, i, 0, 0, 70 + i, 0, 0);
        do_ctrl_done();
        chk("t6_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_en", 64'(mem_wr_en), 64'd0);
        chk("t6_rst_wr", {mem_wr_addr, mem_wr_data}, 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_wcnt", 64'(write_count), 64'd0);
        step();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_no_done", 64'(drain_done), 64'd0);
        end
        chk("t6_no_write", 64'(mem_wr_en), 64'd0);

        do_start();
        beat(3'b010, 3'b111, 0, 2, 0, 0, 99, 0);
        do_ctrl_done();
        wait_done("t7");
        chk("t7_wcnt", 64'(write_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
